ex_muldiv_unit: RTL and testbench



---
 rtl/rv32_defs.sv | 14 +
 rtl/muldiv_datapath.sv | 56 +++++
 rtl/ex_muldiv_unit.sv | 66 ++++++
 tb/tb_ex_muldiv_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rv32_defs.sv
// rv32_defs: RV32M decode constants and muldiv FSM state encoding.
package rv32_defs;
  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared 64-bit accumulator for shift-add multiply and restoring divide, plus sign fix.
module muldiv_datapath import rv32_defs::*; (
  input  logic        clk_I,
  input  logic        reset_I,
  input  logic        load,
  input  logic        special,
  input  logic        step_mul,
  input  logic        step_div,
  input  logic [2:0]  func3_I,
  input  logic [31:0] operandA_I,
  input  logic [31:0] operandB_I,
  output logic [31:0] result_O
);
  logic [63:0] acc, prod;
  logic [31:0] b_abs, a_abs_n, b_abs_n, quo, rem;
  logic [2:0]  f3;
  logic        neg, neg_r, a_sgn, b_sgn, a_neg, b_neg;
  logic [32:0] sum;
  logic [33:0] diff;
  // acc holds {hi, multiplier} while multiplying and {remainder, quotient} while dividing
  always_comb begin
    a_sgn   = func3_I != F3_MULHU && func3_I != F3_DIVU && func3_I != F3_REMU;
    b_sgn   = a_sgn && func3_I != F3_MULHSU;
    a_neg   = a_sgn && operandA_I[31];
    b_neg   = b_sgn && operandB_I[31];
    a_abs_n = a_neg ? -operandA_I : operandA_I;
    b_abs_n = b_neg ? -operandB_I : operandB_I;
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_abs} : 33'd0);
    diff    = {1'b0, acc[63:31]} - {2'b0, b_abs};
    prod    = neg ? -acc : acc;
    quo     = neg ? -acc[31:0] : acc[31:0];
    rem     = neg_r ? -acc[63:32] : acc[63:32];
    result_O = f3[2] ? (f3[1] ? rem : quo) : (f3 == F3_MUL ? prod[31:0] : prod[63:32]);
  end
  // special cases preload the final {rem, quo} with the sign fix disabled
  always_ff @(posedge clk_I) begin
    if (!reset_I) begin
      acc   <= '0;
      b_abs <= '0;
      f3    <= '0;
      neg   <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      f3    <= func3_I;
      b_abs <= b_abs_n;
      neg   <= !special && (a_neg ^ b_neg);
      neg_r <= !special && a_neg;
      acc   <= special ? (operandB_I == 32'd0 ? {operandA_I, 32'hFFFF_FFFF} : 64'h0000_0000_8000_0000)
                       : {32'd0, a_abs_n};
    end else if (step_mul) begin
      acc <= {sum, acc[31:1]};
    end else if (step_div) begin
      acc <= diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative RV32M engine; FSM, iteration counter, stall and special-case detection.
module ex_muldiv_unit import rv32_defs::*; (
  input  logic        clk_I,
  input  logic        reset_I,
  input  logic        valid_I,
  input  logic [6:0]  opCode_I,
  input  logic [2:0]  func3_I,
  input  logic [6:0]  func7_I,
  input  logic [31:0] operandA_I,
  input  logic [31:0] operandB_I,
  input  logic        advance_I,
  input  logic        flush_I,
  output logic        stall_O,
  output logic [31:0] result_O,
  output logic        resultValid_O,
  output logic        isMulDiv_O
);
  state_t      state, nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        start, special;
  logic [31:0] dp_result;
  assign isMulDiv_O = valid_I && opCode_I == OPCODE_RTYPE && func7_I == FUNC7_MULDIV;
  always_comb begin
    start   = state == S_IDLE && isMulDiv_O && !flush_I;
    special = func3_I[2] && (operandB_I == 32'd0 ||
              (!func3_I[0] && operandA_I == 32'h8000_0000 && &operandB_I));
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = start ? 5'd0 : cnt;
        nxt     = start ? (special ? S_DONE : func3_I[2] ? S_DIV : S_MUL) : S_IDLE;
      end
      S_MUL, S_DIV: begin
        cnt_nxt = cnt + 5'd1;
        nxt     = cnt == 5'd31 ? S_DONE : state;
      end
      S_DONE: nxt = advance_I ? S_IDLE : S_DONE;
    endcase
    if (flush_I) nxt = S_IDLE;
    stall_O       = isMulDiv_O && state != S_DONE && !flush_I;
    resultValid_O = state == S_DONE;
    result_O      = resultValid_O ? dp_result : 32'd0;
  end
  always_ff @(posedge clk_I) begin
    if (!reset_I) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end
  muldiv_datapath u_dp (
    .clk_I      (clk_I),
    .reset_I    (reset_I),
    .load       (start),
    .special    (special),
    .step_mul   (state == S_MUL),
    .step_div   (state == S_DIV),
    .func3_I    (func3_I),
    .operandA_I (operandA_I),
    .operandB_I (operandB_I),
    .result_O   (dp_result)
  );
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;
  logic        clk_I = 1'b0, reset_I = 1'b0, valid_I = 1'b0, advance_I = 1'b0, flush_I = 1'b0;
  logic [6:0]  opCode_I = '0, func7_I = '0;
  logic [2:0]  func3_I = '0;
  logic [31:0] operandA_I = '0, operandB_I = '0;
  logic        stall_O, resultValid_O, isMulDiv_O;
  logic [31:0] result_O, held;
  int checks = 0, errors = 0, cyc, st, cnt;

  ex_muldiv_unit dut (
    .clk_I(clk_I), .reset_I(reset_I), .valid_I(valid_I), .opCode_I(opCode_I),
    .func3_I(func3_I), .func7_I(func7_I), .operandA_I(operandA_I), .operandB_I(operandB_I),
    .advance_I(advance_I), .flush_I(flush_I), .stall_O(stall_O), .result_O(result_O),
    .resultValid_O(resultValid_O), .isMulDiv_O(isMulDiv_O)
  );

  always #5 clk_I = ~clk_I;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_I = 1'b1; opCode_I = 7'b0110011; func7_I = 7'b0000001;
    func3_I = f3; operandA_I = a; operandB_I = b; advance_I = 1'b0;
    #1;
  endtask

  task automatic wait_done(output int c, output int s);
    c = 0; s = 0;
    while (!resultValid_O && c < 100) begin
      s += int'(stall_O);
      @(negedge clk_I); #1;
      c++;
    end
  endtask

  task automatic retire();
    advance_I = 1'b1;
    @(negedge clk_I);
    advance_I = 1'b0; valid_I = 1'b0;
    #1;
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clk_I);
    issue(f3, a, b);
    wait_done(cyc, st);
    chk({tag, "_cyc"}, cyc, lat);
    chk({tag, "_stallcnt"}, st, lat);
    chk({tag, "_stall_done"}, {31'd0, stall_O}, 32'd0);
    chk({tag, "_res"}, result_O, exp);
    retire();
  endtask

  initial begin
    repeat (2) @(negedge clk_I);
    #1;
    chk("rst_res", result_O, 32'd0);
    chk("rst_valid", {31'd0, resultValid_O}, 32'd0);
    chk("rst_stall", {31'd0, stall_O}, 32'd0);
    reset_I = 1'b1;

    // MUL 7 x -3, then hold DONE three cycles with advance low
    @(negedge clk_I);
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    chk("mul_ismd", {31'd0, isMulDiv_O}, 32'd1);
    wait_done(cyc, st);
    chk("mul_cyc", cyc, 33);
    chk("mul_stallcnt", st, 33);
    chk("mul_res", result_O, 32'hFFFF_FFEB);
    held = result_O;
    repeat (3) begin
      @(negedge clk_I); #1;
      chk("hold_valid", {31'd0, resultValid_O}, 32'd1);
      chk("hold_res", result_O, held);
      chk("hold_stall", {31'd0, stall_O}, 32'd0);
    end
    retire();

    run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu_z", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_z", 3'b111, 32'd100, 32'd0, 32'd100, 1);

    // back-to-back MULs: second completes at cycle 67 from the first start
    @(negedge clk_I);
    issue(3'b000, 32'd12, 32'd11);
    wait_done(cyc, st);
    chk("b2b1_cyc", cyc, 33);
    chk("b2b1_res", result_O, 32'd132);
    advance_I = 1'b1;
    @(negedge clk_I);
    issue(3'b000, 32'hFFFF_FFFE, 32'd5);
    wait_done(cyc, st);
    chk("b2b2_cyc", cyc + 34, 67);
    chk("b2b2_res", result_O, 32'hFFFF_FFF6);
    retire();

    // flush at cycle 10 of a DIV
    @(negedge clk_I);
    issue(3'b100, 32'd1000, 32'd7);
    repeat (10) @(negedge clk_I);
    flush_I = 1'b1; #1;
    chk("flush_stall", {31'd0, stall_O}, 32'd0);
    @(negedge clk_I);
    flush_I = 1'b0; valid_I = 1'b0; #1;
    cnt = 0;
    repeat (40) begin
      cnt += int'(resultValid_O);
      @(negedge clk_I); #1;
    end
    chk("flush_novalid", cnt, 0);

    // reset at cycle 5 of a MUL
    @(negedge clk_I);
    issue(3'b000, 32'd3, 32'd3);
    repeat (5) @(negedge clk_I);
    reset_I = 1'b0; valid_I = 1'b0;
    @(negedge clk_I); #1;
    chk("mrst_res", result_O, 32'd0);
    chk("mrst_valid", {31'd0, resultValid_O}, 32'd0);
    chk("mrst_stall", {31'd0, stall_O}, 32'd0);
    reset_I = 1'b1;

    // non-M R-type never leaves IDLE
    @(negedge clk_I);
    issue(3'b000, 32'd5, 32'd6);
    func7_I = 7'b0000000; #1;
    chk("nonm_ismd", {31'd0, isMulDiv_O}, 32'd0);
    cnt = 0;
    repeat (5) begin
      cnt += int'(stall_O) + int'(resultValid_O);
      @(negedge clk_I); #1;
    end
    chk("nonm_idle", cnt, 0);
    valid_I = 1'b0;

    // a full op after the mid-op reset still works
    run("post_rst", 3'b111, 32'd100, 32'd7, 32'd2, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
